seg_scan_ctrl: RTL and testbench

- Parametrised N-digit seven-segment scan controller; successor to the fixed 4-digit display multiplexer.
- Adds a programmable refresh prescaler, a hex decoder per digit slot, per-digit decimal point, and double-buffered tear-free digit loading with a frame-boundary update.
- Sits between the calculator/operations logic and the board display pins (anodes/enables/dc).

---
 rtl/seg_scan_ctrl_pkg.sv | 16 +
 rtl/seg_scan_ctrl_if.sv | 27 ++
 rtl/seg_scan_ctrl_hex7seg_dec.sv | 11 +
 rtl/seg_scan_ctrl.sv | 131 +++++++++++++
 tb/tb_seg_scan_ctrl.sv | 225 ++++++++++++++++++++++
 5 files changed

// File: rtl/seg_scan_ctrl_pkg.sv
// Shared types and constants for the seven-segment scan controller:
// the blank pattern and the active-low hex-to-segment table (bit6=g ... bit0=a).
package seg_scan_pkg;

    typedef logic [3:0] nibble_t;

    localparam logic [6:0] SEG_BLANK = 7'h7F;

    localparam logic [6:0] HEX_SEG [16] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
        7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
    };

endpackage

// File: rtl/seg_scan_ctrl_if.sv
// Display-side bundle: digit/dp load path from the operations logic and the
// multiplexed pin drive back out to the board.
interface seg_scan_ctrl_if #(
    parameter int NUM_DIGITS = 4
);

    logic [4*NUM_DIGITS-1:0] digits_in;
    logic [NUM_DIGITS-1:0]   dp_in;
    logic                    load;
    logic                    blank;
    logic                    pending;
    logic                    frame_done;
    logic [6:0]              anodes;
    logic [NUM_DIGITS-1:0]   enables;
    logic                    dc;

    modport master (
        output digits_in, dp_in, load, blank,
        input  pending, frame_done, anodes, enables, dc
    );

    modport slave (
        input  digits_in, dp_in, load, blank,
        output pending, frame_done, anodes, enables, dc
    );

endinterface

// File: rtl/seg_scan_ctrl_hex7seg_dec.sv
// Combinational hex nibble to active-low seven-segment pattern.
module hex7seg_dec
    import seg_scan_pkg::*;
(
    input  nibble_t    nib,
    output logic [6:0] seg
);

    assign seg = HEX_SEG[nib];

endmodule

// File: rtl/seg_scan_ctrl.sv
// N-digit seven-segment scan controller with prescaled refresh and a
// double-buffered, frame-synchronous digit update. Define SEG_SCAN_LZB_EN for leading-zero blanking.
module seg_scan_ctrl
    import seg_scan_pkg::*;
#(
    parameter int NUM_DIGITS = 4,
    parameter int PRESCALE   = 100000
) (
    input logic            clk1,
    input logic            rst,
    seg_scan_ctrl_if.slave disp
);

    localparam int PS_W  = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    localparam logic [PS_W-1:0]  PS_LAST  = PS_W'(PRESCALE - 1);
    localparam logic [PS_W-1:0]  PS_PRE   = PS_W'(PRESCALE - 2);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);

    logic [PS_W-1:0]       ps_cnt;
    logic [IDX_W-1:0]      idx;
    logic                  tick;
    logic                  boundary;
    logic                  frame_done_q;

    nibble_t               sh_dig [NUM_DIGITS];
    nibble_t               pd_dig [NUM_DIGITS];
    logic [NUM_DIGITS-1:0] sh_dp;
    logic [NUM_DIGITS-1:0] pd_dp;
    logic                  pend_q;

    logic [NUM_DIGITS-1:0] lz_mask;
    nibble_t               sel_nib;
    logic [6:0]            dec_seg;

    logic [6:0]            seg_p1;
    logic [NUM_DIGITS-1:0] en_p1;
    logic                  dc_p1;

    assign tick     = (ps_cnt == PS_LAST);
    assign boundary = tick && (idx == IDX_LAST);

    // frame_done is decoded one cycle early so the registered pulse lands on the boundary cycle
    always_ff @(posedge clk1) begin
        if (!rst) begin
            ps_cnt       <= '0;
            idx          <= '0;
            frame_done_q <= 1'b0;
        end else begin
            ps_cnt       <= tick ? '0 : ps_cnt + 1'b1;
            frame_done_q <= (ps_cnt == PS_PRE) && (idx == IDX_LAST);
            if (tick) begin
                idx <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
            end
        end
    end

    always_ff @(posedge clk1) begin
        if (!rst) begin
            for (int i = 0; i < NUM_DIGITS; i++) begin
                sh_dig[i] <= '0;
                pd_dig[i] <= '0;
            end
            sh_dp  <= '0;
            pd_dp  <= '0;
            pend_q <= 1'b0;
        end else begin
            // boundary transfer uses pre-edge pending data, so a colliding load waits a frame
            if (boundary && pend_q) begin
                for (int i = 0; i < NUM_DIGITS; i++) begin
                    sh_dig[i] <= pd_dig[i];
                end
                sh_dp <= pd_dp;
            end
            if (disp.load) begin
                for (int i = 0; i < NUM_DIGITS; i++) begin
                    pd_dig[i] <= disp.digits_in[4*i +: 4];
                end
                pd_dp  <= disp.dp_in;
                pend_q <= 1'b1;
            end else if (boundary) begin
                pend_q <= 1'b0;
            end
        end
    end

`ifdef SEG_SCAN_LZB_EN
    logic leading;

    always_comb begin
        lz_mask = '0;
        leading = 1'b1;
        for (int i = NUM_DIGITS - 1; i > 0; i--) begin
            leading    = leading && (sh_dig[i] == 4'h0) && !sh_dp[i];
            lz_mask[i] = leading;
        end
    end
`else
    always_comb begin
        lz_mask = '0;
    end
`endif

    assign sel_nib = sh_dig[idx];

    hex7seg_dec u_dec (
        .nib (sel_nib),
        .seg (dec_seg)
    );

    // Output register stage: pins follow idx by one cycle
    always_ff @(posedge clk1) begin
        if (!rst || disp.blank) begin
            seg_p1 <= SEG_BLANK;
            en_p1  <= '1;
            dc_p1  <= 1'b1;
        end else begin
            seg_p1 <= lz_mask[idx] ? SEG_BLANK : dec_seg;
            en_p1  <= ~(NUM_DIGITS'(1) << idx);
            dc_p1  <= ~sh_dp[idx];
        end
    end

    assign disp.anodes     = seg_p1;
    assign disp.enables    = en_p1;
    assign disp.dc         = dc_p1;
    assign disp.pending    = pend_q;
    assign disp.frame_done = frame_done_q;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Bench for seg_scan_ctrl (4 digits, prescale 4): directed scenarios plus
// random traffic against a cycle-count based reference model.
module tb_seg_scan_ctrl;

    localparam int N = 4;
    localparam int P = 4;
`ifdef SEG_SCAN_LZB_EN
    localparam bit LZB = 1'b1;
`else
    localparam bit LZB = 1'b0;
`endif

    logic clk1 = 1'b0;
    logic rst  = 1'b0;
    always #5 clk1 = ~clk1;

    seg_scan_ctrl_if #(.NUM_DIGITS(N)) disp ();

    seg_scan_ctrl #(.NUM_DIGITS(N), .PRESCALE(P)) dut (
        .clk1 (clk1),
        .rst  (rst),
        .disp (disp)
    );

    int checks = 0;
    int errors = 0;

    // reference model state
    int         cyc;
    logic [15:0] m_sh, m_pd;
    logic [3:0]  m_sdp, m_pdp, m_en;
    logic        m_pend, m_dc, m_fd;
    logic [6:0]  m_an;
    logic        blank_lvl = 1'b0;

    function automatic logic [6:0] seg_of(input logic [3:0] n);
        case (n)
            4'h0: return 7'b1000000;  4'h1: return 7'b1111001;
            4'h2: return 7'b0100100;  4'h3: return 7'b0110000;
            4'h4: return 7'b0011001;  4'h5: return 7'b0010010;
            4'h6: return 7'b0000010;  4'h7: return 7'b1111000;
            4'h8: return 7'b0000000;  4'h9: return 7'b0010000;
            4'hA: return 7'b0001000;  4'hB: return 7'b0000011;
            4'hC: return 7'b1000110;  4'hD: return 7'b0100001;
            4'hE: return 7'b0000110;  default: return 7'b0001110;
        endcase
    endfunction

    // digit i is dark when it and every digit above it is a zero with no dp
    function automatic bit lz_blank(input int i);
        if (i == 0) return 1'b0;
        for (int j = i; j < N; j++) begin
            if (m_sh[j*4 +: 4] != 4'h0 || m_sdp[j]) return 1'b0;
        end
        return 1'b1;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_edge(input logic l, input logic [15:0] d, input logic [3:0] p,
                              input logic b, input logic r);
        int idx;
        bit bnd;
        if (!r) begin
            cyc = 0; m_sh = '0; m_sdp = '0; m_pd = '0; m_pdp = '0; m_pend = 1'b0;
            m_an = 7'h7F; m_en = 4'hF; m_dc = 1'b1;
        end else begin
            idx = (cyc / P) % N;
            if (b) begin
                m_an = 7'h7F; m_en = 4'hF; m_dc = 1'b1;
            end else begin
                m_en = ~(4'b0001 << idx);
                m_an = (LZB && lz_blank(idx)) ? 7'h7F : seg_of(m_sh[idx*4 +: 4]);
                m_dc = ~m_sdp[idx];
            end
            bnd = (cyc % (P*N)) == (P*N - 1);
            if (bnd && m_pend) begin
                m_sh  = m_pd;
                m_sdp = m_pdp;
            end
            if (l) begin
                m_pd = d; m_pdp = p; m_pend = 1'b1;
            end else if (bnd) begin
                m_pend = 1'b0;
            end
            cyc++;
        end
        m_fd = r && ((cyc % (P*N)) == (P*N - 1));
    endtask

    task automatic step(input logic l, input logic [15:0] d, input logic [3:0] p,
                        input logic b, input logic r);
        disp.load = l; disp.digits_in = d; disp.dp_in = p; disp.blank = b; rst = r;
        @(posedge clk1);
        model_edge(l, d, p, b, r);
        #1;
        check("anodes",     32'(disp.anodes),     32'(m_an));
        check("enables",    32'(disp.enables),    32'(m_en));
        check("dc",         32'(disp.dc),         32'(m_dc));
        check("pending",    32'(disp.pending),    32'(m_pend));
        check("frame_done", 32'(disp.frame_done), 32'(m_fd));
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 16'($urandom), 4'($urandom), blank_lvl, 1'b1);
    endtask

    task automatic load(input logic [15:0] d, input logic [3:0] p);
        step(1'b1, d, p, blank_lvl, 1'b1);
    endtask

    // advance until the DUT reports the frame boundary cycle, bounded
    task automatic wait_frame();
        int k = 0;
        while (disp.frame_done !== 1'b1 && k < 40) begin
            idle(1);
            k++;
        end
        check("frame_wait", 32'(disp.frame_done), 32'd1);
    endtask

    task automatic slot(input string tag, input logic [6:0] an, input logic [3:0] en, input logic dcv);
        check({tag, "_an"}, 32'(disp.anodes),  32'(an));
        check({tag, "_en"}, 32'(disp.enables), 32'(en));
        check({tag, "_dc"}, 32'(disp.dc),      32'(dcv));
    endtask

    initial begin
        // reset held for three cycles
        for (int i = 0; i < 3; i++) step(1'b0, 16'h0, 4'h0, 1'b0, 1'b0);
        slot("rst", 7'h7F, 4'hF, 1'b1);
        check("rst_pending", 32'(disp.pending),    32'd0);
        check("rst_fdone",   32'(disp.frame_done), 32'd0);

        // basic scan of 1234 with dp on digit 2
        load(16'h1234, 4'b0100);
        check("load_pending", 32'(disp.pending), 32'd1);
        wait_frame();
        idle(2);
        slot("s0", 7'b0011001, 4'b1110, 1'b1);
        check("boundary_pending", 32'(disp.pending), 32'd0);
        idle(4);
        slot("s1", 7'b0110000, 4'b1101, 1'b1);

        // tear-free: load mid-frame, current frame unchanged
        load(16'hABCD, 4'b0000);
        check("tf_pending", 32'(disp.pending), 32'd1);
        idle(3);
        slot("s2", 7'b0100100, 4'b1011, 1'b0);
        idle(4);
        slot("s3", 7'b1111001, 4'b0111, 1'b1);
        wait_frame();
        idle(2);
        slot("tf0", 7'b0100001, 4'b1110, 1'b1);
        check("tf_pend_clr", 32'(disp.pending), 32'd0);
        idle(4);
        slot("tf1", 7'b1000110, 4'b1101, 1'b1);
        idle(4);
        slot("tf2", 7'b0000011, 4'b1011, 1'b1);
        idle(4);
        slot("tf3", 7'b0001000, 4'b0111, 1'b1);

        // load colliding with the boundary cycle
        wait_frame();
        idle(2);
        load(16'h5555, 4'b0000);
        wait_frame();
        load(16'h0F0F, 4'b0000);
        check("col_pending", 32'(disp.pending), 32'd1);
        idle(1);
        slot("col0", 7'b0010010, 4'b1110, 1'b1);
        wait_frame();
        idle(2);
        slot("col1", 7'b0001110, 4'b1110, 1'b1);
        idle(4);
        slot("col2", 7'b1000000, 4'b1101, 1'b1);

        // blank mid-slot, then release
        idle(1);
        blank_lvl = 1'b1;
        idle(1);
        slot("blank", 7'h7F, 4'hF, 1'b1);
        idle(6);
        blank_lvl = 1'b0;
        idle(3);

        // reset mid-frame discards pending data
        load(16'h9876, 4'b1010);
        idle(1);
        step(1'b0, 16'h0, 4'h0, 1'b0, 1'b0);
        slot("mrst", 7'h7F, 4'hF, 1'b1);
        check("mrst_pending", 32'(disp.pending), 32'd0);
        idle(2);

        // leading zeros: 0070
        load(16'h0070, 4'b0000);
        wait_frame();
        idle(2);
        slot("lz0", 7'b1000000, 4'b1110, 1'b1);
        idle(4);
        slot("lz1", 7'b1111000, 4'b1101, 1'b1);
        idle(4);
        slot("lz2", LZB ? 7'h7F : 7'b1000000, 4'b1011, 1'b1);
        idle(4);
        slot("lz3", LZB ? 7'h7F : 7'b1000000, 4'b0111, 1'b1);

        // random traffic against the model
        for (int i = 0; i < 500; i++) begin
            if ($urandom_range(0, 29) == 0) blank_lvl = ~blank_lvl;
            step(($urandom_range(0, 7) == 0), 16'($urandom),
                 ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom),
                 blank_lvl, ($urandom_range(0, 99) != 0));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
